// File: rtl/fir_wb_arb_pkg.sv
// Shared types for the two-master FIR Wishbone arbiter.
// The DRAIN state only exists when FIR_WB_ARB_WDOG_EN is defined.
package fir_wb_arb_pkg;

  localparam int TMO_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef FIR_WB_ARB_WDOG_EN
    ST_DRAIN = 2'd2,
`endif
    ST_BUSY  = 2'd1
  } state_t;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

endpackage

// File: rtl/fir_wb_arbiter_if.sv
// One Wishbone channel (classic cycle), used to bundle a master or the slave
// side of the arbiter in the surrounding system.
interface fir_wb_arbiter_if #(parameter int ADR_W = 32);
  logic             cyc;
  logic             stb;
  logic             we;
  logic [3:0]       sel;
  logic [ADR_W-1:0] adr;
  logic [31:0]      dat_w;
  logic [31:0]      dat_r;
  logic             ack;
  logic             err;

  modport master (output cyc, stb, we, sel, adr, dat_w, input  dat_r, ack, err);
  modport slave  (input  cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/fir_wb_arb_wdog.sv
// Stall watchdog: counts owner strobe cycles without ack and flags expiry
// combinationally in the cycle the count would reach 2^TMO_W-1.
module fir_wb_arb_wdog
  import fir_wb_arb_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic stb,
  input  logic ack,
  output logic expire_o
);

  localparam logic [TMO_W-1:0] LAST = ~TMO_W'(1);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             stall;

  // Ack wins over expiry: stall is false whenever ack is high.
  assign stall    = en & stb & ~ack;
  assign expire_o = stall & (cnt_q == LAST);

  always_comb begin
    cnt_d = '0;
    if (stall) cnt_d = cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

endmodule

// File: rtl/fir_wb_arbiter.sv
// Two-master Wishbone arbiter in front of a shared FIR slave; the grant is
// held for the owner's whole cycle. FIR_WB_ARB_WDOG_EN adds a stall watchdog.
module fir_wb_arbiter
  import fir_wb_arb_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF,
  parameter int ADR_W = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [3:0]       m0_sel_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [31:0]      m0_dat_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [31:0]      m0_dat_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [3:0]       m1_sel_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [31:0]      m1_dat_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [31:0]      m1_dat_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [3:0]       s_sel_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [31:0]      s_dat_o,
  input  logic             s_ack_i,
  input  logic [31:0]      s_dat_i,
  output logic [1:0]       gnt_o
);

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t last_q, last_d;
  logic [1:0] gnt_q, gnt_d;

  logic req0, req1;
  logic own_cyc, own_stb, own_we;
  logic [3:0]       own_sel;
  logic [ADR_W-1:0] own_adr;
  logic [31:0]      own_dat;
  logic             wdog_exp;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  assign own_cyc = (owner_q == OWN_M1) ? m1_cyc_i : m0_cyc_i;
  assign own_stb = (owner_q == OWN_M1) ? m1_stb_i : m0_stb_i;
  assign own_we  = (owner_q == OWN_M1) ? m1_we_i  : m0_we_i;
  assign own_sel = (owner_q == OWN_M1) ? m1_sel_i : m0_sel_i;
  assign own_adr = (owner_q == OWN_M1) ? m1_adr_i : m0_adr_i;
  assign own_dat = (owner_q == OWN_M1) ? m1_dat_i : m0_dat_i;

`ifdef FIR_WB_ARB_WDOG_EN
  fir_wb_arb_wdog #(.TMO_W(TMO_W)) u_wdog (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .en       (state_q == ST_BUSY),
    .stb      (own_cyc & own_stb),
    .ack      (s_ack_i),
    .expire_o (wdog_exp)
  );
`else
  assign wdog_exp = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_M0;
      last_q  <= OWN_M1;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE:
        if (req0 | req1) begin
          state_d = ST_BUSY;
          // On a tie, the master that did not own the bus last goes first.
          if (req0 & req1) owner_d = (last_q == OWN_M0) ? OWN_M1 : OWN_M0;
          else             owner_d = req1 ? OWN_M1 : OWN_M0;
        end
      ST_BUSY:
        if (!own_cyc) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end
`ifdef FIR_WB_ARB_WDOG_EN
        else if (wdog_exp) state_d = ST_DRAIN;
      ST_DRAIN:
        if (!own_cyc) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end
`endif
      default: state_d = ST_IDLE;
    endcase
    gnt_d = 2'b00;
    if (state_d != ST_IDLE) gnt_d = (owner_d == OWN_M1) ? 2'b10 : 2'b01;
  end

  assign gnt_o = gnt_q;

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    // Only BUSY connects the owner; IDLE and DRAIN keep the slave quiet.
    if (state_q == ST_BUSY) begin
      s_cyc_o = own_cyc;
      s_stb_o = own_stb;
      s_we_o  = own_we;
      s_sel_o = own_sel;
      s_adr_o = own_adr;
      s_dat_o = own_dat;
      if (owner_q == OWN_M1) begin
        m1_ack_o = s_ack_i;
        m1_err_o = wdog_exp;
        m1_dat_o = s_dat_i;
      end else begin
        m0_ack_o = s_ack_i;
        m0_err_o = wdog_exp;
        m0_dat_o = s_dat_i;
      end
    end
  end

endmodule

// File: doc/fir_wb_arbiter.md
FIR_WB_ARBITER -- requirements
Module: fir_wb_arbiter

Interface
REQ-001 SHALL have parameter TMO_W, default 8: width of the watchdog counter; timeout = 2^TMO_W-1 cycles.
REQ-002 SHALL have parameter ADR_W, default 32: address width passed through.
REQ-003 SHALL have port wb_clk_i input 1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i input 1: asynchronous, active-high reset.
REQ-005 SHALL have ports mX_cyc_i / mX_stb_i / mX_we_i input 1, X=0,1: Wishbone cycle, strobe and write-enable from master X.
REQ-006 SHALL have ports mX_sel_i input 4, mX_adr_i input ADR_W, mX_dat_i input 32: byte select, address and write data from master X.
REQ-007 SHALL have ports mX_ack_o / mX_err_o output 1 and mX_dat_o output 32: acknowledge, error and read data to master X.
REQ-008 SHALL have ports s_cyc_o / s_stb_o / s_we_o output 1, s_sel_o output 4, s_adr_o output ADR_W, s_dat_o output 32: request to the shared FIR Wishbone slave.
REQ-009 SHALL have ports s_ack_i input 1 and s_dat_i input 32: slave acknowledge (may be combinational) and read data.
REQ-010 SHALL have port gnt_o output 2: one-hot current owner, 2'b00 when idle.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY and DRAIN; DRAIN exists only with the macro in REQ-025.
REQ-012 IDLE: slave outputs all 0; on any mX_cyc_i&mX_stb_i, SHALL register the owner and enter BUSY next cycle (1-cycle arbitration latency).
REQ-013 Both requesting in IDLE: SHALL grant the master that is not last_owner; a single requester SHALL be granted directly.
REQ-014 BUSY: s_* SHALL equal the owner's inputs combinationally, with s_cyc_o=owner cyc and s_stb_o=owner stb.
REQ-015 BUSY: owner ack SHALL equal s_ack_i and owner dat SHALL equal s_dat_i, with no added latency; the non-owner SHALL see ack=0, err=0, dat=0.
REQ-016 Grant SHALL be held for the whole owner cycle, including multi-beat cycles with stb toggling, so that slave-side channel handshake state is never split across masters.
REQ-017 Release: owner cyc low in BUSY SHALL return to IDLE next cycle and update last_owner.
REQ-018 A final ack and cyc drop in the same cycle SHALL be a normal release.
REQ-019 A non-owner request during BUSY SHALL stall with no ack and no side effects, and SHALL be arbitrated in the IDLE cycle after release.
REQ-020 gnt_o SHALL be registered and reflect the FSM owner.

Reset
REQ-021 On wb_rst_i, immediately and asynchronously: state=IDLE, gnt_o=0, last_owner=1 (master 0 wins the first tie), watchdog=0.
REQ-022 On wb_rst_i, all mX_ack_o/mX_err_o/mX_dat_o and s_* outputs SHALL be 0.
REQ-023 Reset mid-transaction SHALL abort the transaction without any ack or err.
REQ-024 After reset deassertion, the first grant SHALL be no earlier than the first clock edge.

Configuration
REQ-025 Macro FIR_WB_ARB_WDOG_EN, when defined, SHALL count cycles with owner stb=1 and s_ack_i=0, clearing on ack or stb=0.
REQ-026 On the count reaching 2^TMO_W-1, the arbiter SHALL pulse owner err_o for 1 cycle, force s_cyc_o/s_stb_o=0 and enter DRAIN; DRAIN SHALL return to IDLE when the owner cyc is low.
REQ-027 With the macro defined, ack and expiry in the same cycle SHALL resolve to ack: no err, counter cleared.
REQ-028 Without the macro: no counter, mX_err_o tied 0, no DRAIN state, and a stalled owner holds the grant indefinitely.

Structure
REQ-029 Package fir_wb_arb_pkg SHALL hold the state enum, the owner encoding (OWN_M0/OWN_M1) and the default TMO_W.
REQ-030 The watchdog SHALL be sub-module fir_wb_arb_wdog (counter plus expiry pulse), instantiated only under the macro.

Verification
REQ-031 m0 alone writes 0x10 data 0x0000000B -> grant after 1 cycle; s_adr_o=0x10; m0_ack_o on the s_ack_i cycle; gnt_o=01.
REQ-032 m0 and m1 request in the same cycle after reset -> m0 granted first, m1 after m0 cyc drops; a second tie goes to m1.
REQ-033 m1 requests while m0 holds a 3-beat cycle -> m1_ack_o=0 throughout; m1 granted 1 cycle after m0 release.
REQ-034 m1 reads 0x80 with slave returning 0x12345678 -> m1_dat_o=0x12345678 on ack; m0_dat_o=0.
REQ-035 Macro on, TMO_W=4, slave never acks -> m0_err_o pulses on cycle 15 of stall; s_cyc_o=0; IDLE after m0 cyc drops.
REQ-036 wb_rst_i asserted mid-BUSY -> all outputs 0 in the same cycle; after release, m0 wins the next tie.
